// File: rtl/freq_byte_serializer.sv
// Byte-to-frame serializer feeding the frequency encoder: start bit, 8 data bits LSB first,
// optional even parity, stop bits; one-entry holding buffer allows gap-free back-to-back frames.
module freq_byte_serializer #(
    parameter int SYMBOL_CYCLES = 4,
    parameter int PARITY_EN     = 1,
    parameter int STOP_BITS     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       data_bit,
    output logic       symbol_strobe,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(SYMBOL_CYCLES + 1);
    localparam logic [CW-1:0] SYM_LAST  = CW'(SYMBOL_CYCLES - 1);
    localparam logic [CW-1:0] SYM_ONE   = CW'(1);
    localparam logic          STOP_LAST = (STOP_BITS > 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   sym_cnt, sym_cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic            stop_cnt, stop_cnt_n;
    logic [7:0]      shifter, shifter_n;
    logic [7:0]      buf_data, buf_data_n;
    logic            buf_valid, buf_valid_n;
    logic            data_bit_n, strobe_n, done_n;
    logic            sym_end, load;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sym_cnt       <= '0;
            bit_idx       <= '0;
            stop_cnt      <= 1'b0;
            shifter       <= '0;
            buf_data      <= '0;
            buf_valid     <= 1'b0;
            in_ready      <= 1'b1;
            data_bit      <= 1'b1;
            symbol_strobe <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_n;
            sym_cnt       <= sym_cnt_n;
            bit_idx       <= bit_idx_n;
            stop_cnt      <= stop_cnt_n;
            shifter       <= shifter_n;
            buf_data      <= buf_data_n;
            buf_valid     <= buf_valid_n;
            in_ready      <= !buf_valid_n;
            data_bit      <= data_bit_n;
            symbol_strobe <= strobe_n;
            frame_done    <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        sym_cnt_n   = sym_cnt;
        bit_idx_n   = bit_idx;
        stop_cnt_n  = stop_cnt;
        shifter_n   = shifter;
        buf_data_n  = buf_data;
        buf_valid_n = buf_valid;
        data_bit_n  = data_bit;
        strobe_n    = 1'b0;
        done_n      = 1'b0;
        load        = 1'b0;

        if (in_valid && in_ready) begin
            buf_valid_n = 1'b1;
            buf_data_n  = in_data;
        end

        sym_end = enable && (sym_cnt == SYM_LAST);
        if (state != IDLE && enable)
            sym_cnt_n = sym_end ? '0 : sym_cnt + SYM_ONE;

        case (state)
            IDLE: begin
                data_bit_n = 1'b1;
                load       = buf_valid;
            end
            START: if (sym_end) begin
                state_n    = DATA;
                bit_idx_n  = '0;
                data_bit_n = shifter[0];
                strobe_n   = 1'b1;
            end
            DATA: if (sym_end) begin
                strobe_n = 1'b1;
                if (bit_idx == 3'd7) begin
                    bit_idx_n = '0;
                    if (PARITY_EN != 0) begin
                        state_n    = PARITY;
                        data_bit_n = ^shifter;
                    end else begin
                        state_n    = STOP;
                        stop_cnt_n = 1'b0;
                        data_bit_n = 1'b1;
                    end
                end else begin
                    bit_idx_n  = bit_idx + 3'd1;
                    data_bit_n = shifter[bit_idx + 3'd1];
                end
            end
            PARITY: if (sym_end) begin
                state_n    = STOP;
                stop_cnt_n = 1'b0;
                data_bit_n = 1'b1;
                strobe_n   = 1'b1;
            end
            STOP: if (sym_end) begin
                if (stop_cnt == STOP_LAST) begin
                    done_n     = 1'b1;
                    stop_cnt_n = 1'b0;
                    // A buffered byte chains straight into the next start bit.
                    if (buf_valid) begin
                        load = 1'b1;
                    end else begin
                        state_n    = IDLE;
                        data_bit_n = 1'b1;
                    end
                end else begin
                    stop_cnt_n = 1'b1;
                    data_bit_n = 1'b1;
                    strobe_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            shifter_n   = buf_data;
            buf_valid_n = 1'b0;
            state_n     = START;
            data_bit_n  = 1'b0;
            strobe_n    = 1'b1;
            sym_cnt_n   = '0;
            bit_idx_n   = '0;
            stop_cnt_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_byte_serializer.sv
// Self-checking bench for freq_byte_serializer: directed vector table, hand-written
// chaining/reset sequences and randomized traffic checked by a frame-level reference model.
module tb_freq_byte_serializer;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst, enable, in_valid, in_ready, data_bit, symbol_strobe, busy, frame_done;
    logic [7:0] in_data;
    logic       in_valid2, in_ready2, data_bit2, strobe2, busy2, done2;
    logic [7:0] in_data2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int en_mode = 0;

    logic [7:0] tx_q[$];
    int         acc_log[$];
    int         log_s_cyc[$];
    logic       log_s_bit[$];
    int         log_d[$];
    int         busy_cnt;

    logic       sym_q[$];
    logic [7:0] pend_q[$];
    logic [7:0] mb;
    int         en_cnt = 0;
    int         idle_wait = 0;

    typedef struct {
        logic [7:0]  data;
        int          mode;
        logic [0:10] bits;
        int          sym_clk;
    } vec_t;

    vec_t        vecs[6];
    vec_t        vecs2[2];
    logic [0:10] got;

    freq_byte_serializer dut (
        .clk(clk), .reset(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .data_bit(data_bit), .symbol_strobe(symbol_strobe),
        .busy(busy), .frame_done(frame_done)
    );

    freq_byte_serializer #(.SYMBOL_CYCLES(4), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(rst), .enable(enable), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .data_bit(data_bit2), .symbol_strobe(strobe2),
        .busy(busy2), .frame_done(done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got_v, exp_v, $time);
        end
    endtask

    // enable pattern: 0 = always high, 1 = toggle every clock, 2 = random (3/4 high)
    always @(posedge clk) begin
        #1;
        case (en_mode)
            1:       enable = ~enable;
            2:       enable = ($urandom_range(0, 3) != 0);
            default: enable = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            acc_log.push_back(cyc);
            tx_q.delete(0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (tx_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = tx_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    end

    // Reference model: a queue of expected symbol values per frame plus an enable-tick budget per symbol.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_data_bit", data_bit, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_in_ready", in_ready, 1'b1);
            check("rst_strobe", symbol_strobe, 1'b0);
            check("rst_done", frame_done, 1'b0);
            sym_q.delete();
            pend_q.delete();
            en_cnt    = 0;
            idle_wait = 0;
        end else begin
            if (frame_done) begin
                log_d.push_back(cyc);
                check("done_last_symbol", sym_q.size(), 1);
                check("done_sym_len", en_cnt, SC);
                if (sym_q.size() > 0) sym_q.delete(0);
            end
            if (symbol_strobe) begin
                log_s_cyc.push_back(cyc);
                log_s_bit.push_back(data_bit);
                if (sym_q.size() > 0) begin
                    check("sym_len", en_cnt, SC);
                    sym_q.delete(0);
                    check("frame_without_done", sym_q.size() > 0, 1'b1);
                end
                if (sym_q.size() == 0) begin
                    check("start_has_byte", pend_q.size() > 0, 1'b1);
                    if (pend_q.size() > 0) begin
                        mb = pend_q.pop_front();
                        sym_q.push_back(1'b0);
                        for (int i = 0; i < 8; i++) sym_q.push_back(mb[i]);
                        sym_q.push_back(1'($countones(mb) % 2));
                        sym_q.push_back(1'b1);
                    end
                end
                en_cnt = 0;
            end
            if (sym_q.size() > 0) begin
                check("data_bit", data_bit, sym_q[0]);
                check("busy_active", busy, 1'b1);
                check("sym_overrun", en_cnt < SC, 1'b1);
                idle_wait = 0;
            end else begin
                check("idle_data_bit", data_bit, 1'b1);
                check("idle_busy", busy, 1'b0);
                if (pend_q.size() > 0) begin
                    idle_wait++;
                    check("idle_start_latency", idle_wait <= 1, 1'b1);
                end else begin
                    idle_wait = 0;
                end
            end
            check("in_ready", in_ready, pend_q.size() == 0);
            if (sym_q.size() > 0 && enable) en_cnt++;
            if (in_valid && in_ready) pend_q.push_back(in_data);
            if (busy) busy_cnt++;
        end
    end

    task automatic start_case();
        @(posedge clk);
        #2;
        log_s_cyc.delete();
        log_s_bit.delete();
        log_d.delete();
        acc_log.delete();
        busy_cnt = 0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int maxc);
        int quiet = 0;
        int n     = 0;
        while (quiet < 2 && n < maxc) begin
            @(negedge clk);
            n++;
            if (tx_q.size() == 0 && !in_valid && in_ready && !busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 2) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", maxc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish before 1 ms");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int s2c[$];
        logic s2b[$];
        int d2;

        vecs[0] = '{8'hA5, 0, 11'b01010010101, 4};
        vecs[1] = '{8'h3C, 1, 11'b00011110001, 8};
        vecs[2] = '{8'h00, 0, 11'b00000000001, 4};
        vecs[3] = '{8'hFF, 0, 11'b01111111101, 4};
        vecs[4] = '{8'h01, 0, 11'b01000000011, 4};
        vecs[5] = '{8'h80, 1, 11'b00000000111, 8};
        vecs2[0] = '{8'h01, 0, 11'b01000000011, 4};
        vecs2[1] = '{8'hA5, 0, 11'b01010010111, 4};

        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0;
        in_valid2 = 1'b0; in_data2 = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // idle after reset
        start_case();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_strobe", symbol_strobe, 1'b0);
            check("idle_done", frame_done, 1'b0);
        end
        check("idle_no_symbols", log_s_cyc.size(), 0);

        // single frames from idle
        for (int v = 0; v < 6; v++) begin
            en_mode = vecs[v].mode;
            start_case();
            tx_q.push_back(vecs[v].data);
            wait_idle(600);
            check("vec_n_symbols", log_s_cyc.size(), 11);
            check("vec_n_done", log_d.size(), 1);
            if (log_s_cyc.size() == 11 && log_d.size() == 1 && acc_log.size() == 1) begin
                for (int k = 0; k < 11; k++) got[k] = log_s_bit[k];
                check("vec_bits", got, vecs[v].bits);
                check("vec_start_latency", log_s_cyc[0] - acc_log[0], 2);
                if (vecs[v].mode == 0) check("vec_frame_len", log_d[0] - log_s_cyc[0], 11 * SC);
                for (int k = 1; k < 10; k++)
                    check("vec_sym_interval", log_s_cyc[k+1] - log_s_cyc[k], vecs[v].sym_clk);
                check("vec_last_interval", log_d[0] - log_s_cyc[10], vecs[v].sym_clk);
            end
        end

        // back-to-back with a third byte stalled behind the buffer
        en_mode = 0;
        start_case();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h5A);
        wait_idle(800);
        check("b2b_n_symbols", log_s_cyc.size(), 33);
        check("b2b_n_done", log_d.size(), 3);
        check("b2b_busy_cycles", busy_cnt, 3 * 11 * SC);
        if (log_s_cyc.size() == 33 && log_d.size() == 3 && acc_log.size() == 3) begin
            check("b2b_second_accept", acc_log[1] - acc_log[0], 2);
            check("b2b_chain_gap", log_s_cyc[11] - log_s_cyc[0], 11 * SC);
            check("b2b_done_at_chain", log_d[0], log_s_cyc[11]);
            check("b2b_third_stall", acc_log[2], log_s_cyc[11]);
            check("b2b_stop_then_start", {log_s_bit[10], log_s_bit[11]}, 2'b10);
            check("b2b_last_len", log_d[2] - log_s_cyc[22], 11 * SC);
        end

        // no parity, two stop bits
        for (int v = 0; v < 2; v++) begin
            s2c.delete();
            s2b.delete();
            d2 = -1;
            @(negedge clk);
            check("p0_ready", in_ready2, 1'b1);
            in_data2  = vecs2[v].data;
            in_valid2 = 1'b1;
            @(posedge clk);
            #1 in_valid2 = 1'b0;
            in_data2 = ~vecs2[v].data;
            for (int n = 0; n < 300 && d2 < 0; n++) begin
                @(negedge clk);
                if (strobe2) begin
                    s2c.push_back(cyc);
                    s2b.push_back(data_bit2);
                end
                if (done2) d2 = cyc;
            end
            check("p0_n_symbols", s2c.size(), 11);
            if (s2c.size() == 11 && d2 >= 0) begin
                for (int k = 0; k < 11; k++) got[k] = s2b[k];
                check("p0_bits", got, vecs2[v].bits);
                check("p0_frame_len", d2 - s2c[0], 11 * SC);
            end
            check("p0_busy_end", busy2, 1'b0);
            check("p0_idle_bit", data_bit2, 1'b1);
        end

        // reset during data bit 3 with a byte buffered
        start_case();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        for (int n = 0; n < 200 && log_s_cyc.size() < 5; n++) @(negedge clk);
        check("mid_reached_bit3", log_s_cyc.size(), 5);
        check("mid_buffered", in_ready, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_data_bit", data_bit, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_strobe", symbol_strobe, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        start_case();
        repeat (60) @(negedge clk);
        check("mid_no_residual_symbols", log_s_cyc.size(), 0);
        check("mid_no_residual_done", log_d.size(), 0);

        // randomized traffic with random enable
        en_mode = 2;
        start_case();
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            tx_q.push_back(8'($urandom));
        end
        wait_idle(6000);
        check("rand_n_done", log_d.size(), 30);
        check("rand_n_symbols", log_s_cyc.size(), 330);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
